// File: rtl/hzd_pkg.sv
// ============================================================================
// Module      : hzd_pkg
// Description : Shared opcode/funct constants, timing encodings, instruction
//               classes and FSM states for the pipeline hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hzd_pkg;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_ORI   = 6'b001101;
    localparam logic [5:0] c_OP_LUI   = 6'b001111;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_JAL   = 6'b000011;

    localparam logic [5:0] c_FN_ADDU  = 6'b100001;
    localparam logic [5:0] c_FN_SUBU  = 6'b100011;
    localparam logic [5:0] c_FN_JR    = 6'b001000;
    localparam logic [5:0] c_FN_MULT  = 6'b011000;
    localparam logic [5:0] c_FN_MULTU = 6'b011001;
    localparam logic [5:0] c_FN_DIV   = 6'b011010;
    localparam logic [5:0] c_FN_DIVU  = 6'b011011;
    localparam logic [5:0] c_FN_MFHI  = 6'b010000;
    localparam logic [5:0] c_FN_MFLO  = 6'b010010;
    localparam logic [5:0] c_FN_MTHI  = 6'b010001;
    localparam logic [5:0] c_FN_MTLO  = 6'b010011;

    typedef logic [1:0] t_time;
    localparam t_time c_T0 = 2'd0;
    localparam t_time c_T1 = 2'd1;
    localparam t_time c_T2 = 2'd2;

    typedef enum logic [3:0] {
        CL_NONE, CL_ALUR, CL_ALUI, CL_LUI, CL_LW, CL_SW,
        CL_BEQ, CL_JAL, CL_JR, CL_MDS, CL_MF, CL_MT
    } t_cls;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUSY = 1'b1} t_state;

    typedef struct packed {
        logic       rs_rd;
        logic       rt_rd;
        t_time      tuse_rs;
        t_time      tuse_rt;
        t_time      tnew_e;
        t_time      tnew_m;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dst;
        logic       md_cls;
        logic       md_start;
        logic       is_div;
    } t_dec;

    function automatic t_cls classify(input logic [31:0] ins);
        t_cls cls;
        cls = CL_NONE;
        case (ins[31:26])
            c_OP_RTYPE: begin
                case (ins[5:0])
                    c_FN_ADDU, c_FN_SUBU:                       cls = CL_ALUR;
                    c_FN_JR:                                    cls = CL_JR;
                    c_FN_MULT, c_FN_MULTU, c_FN_DIV, c_FN_DIVU: cls = CL_MDS;
                    c_FN_MFHI, c_FN_MFLO:                       cls = CL_MF;
                    c_FN_MTHI, c_FN_MTLO:                       cls = CL_MT;
                    default:                                    cls = CL_NONE;
                endcase
            end
            c_OP_ORI: cls = CL_ALUI;
            c_OP_LUI: cls = CL_LUI;
            c_OP_LW:  cls = CL_LW;
            c_OP_SW:  cls = CL_SW;
            c_OP_BEQ: cls = CL_BEQ;
            c_OP_JAL: cls = CL_JAL;
            default:  cls = CL_NONE;
        endcase
        return cls;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hzd_dec.sv
// ============================================================================
// Module      : hzd_dec
// Description : Combinational instruction decoder: source usage, Tuse, Tnew
//               and destination register for one pipeline stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hzd_dec
    import hzd_pkg::*;
(
    input  logic [31:0] i_ins,
    output t_dec        o_dec
);

    t_cls w_cls;
    logic w_unused;

    assign w_cls    = classify(i_ins);
    assign w_unused = ^i_ins[10:6];

    always_comb begin
        o_dec    = '0;
        o_dec.rs = i_ins[25:21];
        o_dec.rt = i_ins[20:16];
        case (w_cls)
            CL_ALUR: begin
                o_dec.rs_rd   = 1'b1;
                o_dec.rt_rd   = 1'b1;
                o_dec.tuse_rs = c_T1;
                o_dec.tuse_rt = c_T1;
                o_dec.tnew_e  = c_T1;
                o_dec.dst     = i_ins[15:11];
            end
            CL_ALUI: begin
                o_dec.rs_rd   = 1'b1;
                o_dec.tuse_rs = c_T1;
                o_dec.tnew_e  = c_T1;
                o_dec.dst     = i_ins[20:16];
            end
            CL_LUI: begin
                o_dec.tnew_e  = c_T1;
                o_dec.dst     = i_ins[20:16];
            end
            CL_LW: begin
                o_dec.rs_rd   = 1'b1;
                o_dec.tuse_rs = c_T1;
                o_dec.tnew_e  = c_T2;
                o_dec.tnew_m  = c_T1;
                o_dec.dst     = i_ins[20:16];
            end
            CL_SW: begin
                o_dec.rs_rd   = 1'b1;
                o_dec.rt_rd   = 1'b1;
                o_dec.tuse_rs = c_T1;
                o_dec.tuse_rt = c_T2;
            end
            CL_BEQ: begin
                o_dec.rs_rd   = 1'b1;
                o_dec.rt_rd   = 1'b1;
                o_dec.tuse_rs = c_T0;
                o_dec.tuse_rt = c_T0;
            end
            CL_JAL: begin
                o_dec.tnew_e  = c_T0;
                o_dec.dst     = 5'd31;
            end
            CL_JR: begin
                o_dec.rs_rd   = 1'b1;
                o_dec.tuse_rs = c_T0;
            end
            CL_MDS: begin
                o_dec.rs_rd    = 1'b1;
                o_dec.rt_rd    = 1'b1;
                o_dec.tuse_rs  = c_T1;
                o_dec.tuse_rt  = c_T1;
                o_dec.md_cls   = 1'b1;
                o_dec.md_start = 1'b1;
                o_dec.is_div   = i_ins[1];
            end
            CL_MF: begin
                o_dec.tnew_e  = c_T1;
                o_dec.dst     = i_ins[15:11];
                o_dec.md_cls  = 1'b1;
            end
            CL_MT: begin
                o_dec.rs_rd   = 1'b1;
                o_dec.tuse_rs = c_T1;
                o_dec.md_cls  = 1'b1;
            end
            default: o_dec.dst = 5'd0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/hzd_ctl.sv
// ============================================================================
// Module      : hzd_ctl
// Description : Hazard/stall controller for the five-stage MIPS pipeline.
//               Optional stall-cycle counter enabled by macro HZD_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hzd_ctl
    import hzd_pkg::*;
#(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10,
    parameter int CNT_W   = 4
) (
    input  logic        hzd_clk_H_i,
    input  logic        hzd_rstn_H_i,
    input  logic [31:0] hzd_str_D_i,
    input  logic [31:0] hzd_str_E_i,
    input  logic [31:0] hzd_str_M_i,
    output logic        hzd_pcen_F_o,
    output logic        hzd_den_D_o,
    output logic        hzd_clr_E_o,
    output logic        hzd_busy_H_o
`ifdef HZD_PERF_EN
    ,
    output logic [31:0] hzd_scnt_H_o
`endif
);

    localparam int c_MUL_LD_I = (MUL_LAT > 2) ? MUL_LAT - 2 : 0;
    localparam int c_DIV_LD_I = (DIV_LAT > 2) ? DIV_LAT - 2 : 0;
    localparam logic [CNT_W-1:0] c_MUL_LD = c_MUL_LD_I[CNT_W-1:0];
    localparam logic [CNT_W-1:0] c_DIV_LD = c_DIV_LD_I[CNT_W-1:0];

    t_dec             w_dec_d;
    t_dec             w_dec_e;
    t_dec             w_dec_m;
    t_state           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_ld;
    logic             w_busy;
    logic             w_ldu_stall;
    logic             w_stall;

    hzd_dec u_dec_d (.i_ins(hzd_str_D_i), .o_dec(w_dec_d));
    hzd_dec u_dec_e (.i_ins(hzd_str_E_i), .o_dec(w_dec_e));
    hzd_dec u_dec_m (.i_ins(hzd_str_M_i), .o_dec(w_dec_m));

    function automatic logic src_hit(input logic rd, input logic [4:0] rg, input t_time tuse,
                                     input t_dec e, input t_dec m);
        return rd && (rg != 5'd0) &&
               (((rg == e.dst) && (tuse < e.tnew_e)) || ((rg == m.dst) && (tuse < m.tnew_m)));
    endfunction

    assign w_ldu_stall = src_hit(w_dec_d.rs_rd, w_dec_d.rs, w_dec_d.tuse_rs, w_dec_e, w_dec_m) |
                         src_hit(w_dec_d.rt_rd, w_dec_d.rt, w_dec_d.tuse_rt, w_dec_e, w_dec_m);

    // Busy covers the start cycle itself, so an md op paired with a start stalls.
    assign w_busy  = w_dec_e.md_start | (r_state == ST_BUSY);
    assign w_stall = w_ldu_stall | (w_dec_d.md_cls & w_busy);
    assign w_ld    = w_dec_e.is_div ? c_DIV_LD : c_MUL_LD;

    assign hzd_pcen_F_o = hzd_rstn_H_i & ~w_stall;
    assign hzd_den_D_o  = hzd_rstn_H_i & ~w_stall;
    assign hzd_clr_E_o  = ~hzd_rstn_H_i | w_stall;
    assign hzd_busy_H_o = hzd_rstn_H_i & w_busy;

    always_ff @(posedge hzd_clk_H_i or negedge hzd_rstn_H_i) begin
        if (!hzd_rstn_H_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else if (w_dec_e.md_start) begin
            r_cnt   <= w_ld;
            r_state <= (w_ld == '0) ? ST_IDLE : ST_BUSY;
        end else if (r_state == ST_BUSY) begin
            if (r_cnt == '0) begin
                r_state <= ST_IDLE;
            end else begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

`ifdef HZD_PERF_EN
    logic [31:0] r_scnt;

    always_ff @(posedge hzd_clk_H_i or negedge hzd_rstn_H_i) begin
        if (!hzd_rstn_H_i) begin
            r_scnt <= '0;
        end else if (w_stall && (r_scnt != 32'hFFFF_FFFF)) begin
            r_scnt <= r_scnt + 32'd1;
        end
    end

    assign hzd_scnt_H_o = r_scnt;
`endif

    logic w_unused;
    assign w_unused = ^{w_dec_d, w_dec_e, w_dec_m};

endmodule

`default_nettype wire
